instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Reader side of the program memory. Holds the program counter and drives the byte address into program memory.
- Program memory returns a combinational 32-bit window: byte[addr] in [31:24] through byte[addr+3] in [7:0].
- Pre-decodes the length of the supported x86 subset and fetches a second window for 5-byte instructions.
- Hands one left-aligned instruction at a time to the decode stage over a valid/ready handshake; accepts branch/call/ret redirects.

Parameters:
- RESET_PC, 32'h0000000b, program counter value loaded on reset (entry point).
- MEM_BYTES, 256, program memory depth in bytes; bounds check for fetch_fault.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low; sampled low on a rising clk edge resets the block
- fetch_addr  output  32  byte address to program memory
- fetch_data  input  32  window from program memory; byte[fetch_addr] in [31:24]
- instr_valid  output  1  instruction bundle valid
- instr_ready  input  1  decode stage accepts bundle
- instr_pc  output  32  address of first byte of bundle
- instr_bytes  output  40  instruction bytes, first byte in [39:32], unused bytes zero
- instr_len  output  3  length 1..5
- instr_illegal  output  1  opcode/ModRM outside supported subset
- redirect_valid  input  1  load new PC
- redirect_addr  input  32  new PC
- fetch_fault  output  1  sticky; window would exceed MEM_BYTES

Behaviour:
- Reset (reset==0 at edge): pc=RESET_PC, state=FETCH0, instr_valid=0, instr_bytes=0, instr_len=0, instr_illegal=0, instr_pc=0, fetch_fault=0. fetch_addr follows the state rule below, so it equals RESET_PC in the first cycle after reset. Reset mid-operation discards any pending bundle.
- fetch_addr is combinational: pc in FETCH0 and VALID, pc+4 in FETCH1.
- FETCH0:
  - Edge captures fetch_data into instr_bytes[39:8] and clears [7:0]; instr_pc=pc.
  - Length is decoded from b0=[31:24] and b1=[23:16] of the window.
  - len 5 -> FETCH1; len 1..4 -> VALID, with instr_bytes masked to zero beyond len.
- FETCH1: edge captures fetch_data[31:24] into instr_bytes[7:0] -> VALID.
- VALID:
  - instr_valid=1; the bundle is held stable until accepted.
  - instr_ready=1 at an edge -> pc=pc+len (32-bit wrap), instr_valid=0, -> FETCH0.
- Bubbles: minimum 2 cycles per instruction of len<=4, 3 cycles for len 5.
- Length decode (mod=b1[7:6]):
  - 55, 5D, C3, C9 -> 1
  - 6A -> 2
  - B8..BF, E8 -> 5
  - 89/8B: mod 11 -> 2; mod 01 -> 3
  - 83: mod 11 -> 3; mod 01 -> 4
  - anything else -> len 1, instr_illegal=1. Illegal bundles are still delivered; the decode stage traps them.
- Redirect:
  - redirect_valid=1 at an edge, in any state, has priority: pc=redirect_addr, instr_valid=0, -> FETCH0, pending bytes discarded.
  - Simultaneous redirect_valid and instr_ready in VALID: bundle counts as accepted, pc=redirect_addr (not pc+len).
- Fault:
  - In FETCH0, if pc > MEM_BYTES-4 (or pc+4 > MEM_BYTES-4 when len=5): fetch_fault=1, state=HALT, instr_valid=0.
  - HALT: no further fetches, fetch_addr frozen; left only by reset. Redirect ignored.
- Arithmetic: all PC math unsigned 32-bit. len is zero-extended before the add.

Test Plan:
- Reset, memory bytes at 0x0b..0x0d = 55 89 E5, ready=1 -> bundles pc=0x0b len1 instr_bytes=0x5500000000; then pc=0x0c len2 instr_bytes=0x89E5000000; fetch_addr=0x0e after the second accept.
- pc=0x10, bytes E8 EB FF FF FF -> visits FETCH1 (fetch_addr=0x14); bundle len5 instr_bytes=0xE8EBFFFFFF, illegal=0, instr_valid asserted 2 cycles after FETCH0 entry.
- Bundle at 0x03 (8B 45 08) held with ready=0 for 5 cycles -> outputs stable, len3; ready=1 -> next pc=0x06, bundle 83 E8 01 len3.
- In VALID at pc=0x15, assert redirect_valid with redirect_addr=0x00 together with ready -> next fetch_addr=0x00, first bundle 55 at pc=0; redirect during FETCH1 discards the partial 5-byte bundle.
- Byte 0x0F at pc -> len1, instr_illegal=1, next pc=pc+1; byte 0x83 with ModRM 0x45 -> len4.
- Redirect to 0xFE (MEM_BYTES=256) -> fetch_fault=1, instr_valid stays 0 and fetch_addr stays 0xFE through later redirects; reset low -> fault clears, fetch_addr=0x0b.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, pre-decodes x86-subset
// instruction lengths and hands left-aligned bundles to decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000000b,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [39:0] instr_bytes,
    output logic [2:0]  instr_len,
    output logic        instr_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        FETCH0,
        FETCH1,
        VALID,
        HALT
    } state_t;

    // Highest start address whose 4-byte window still fits in program memory.
    localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [2:0]  dec_len;
    logic        dec_illegal;
    logic [39:0] len_mask;
    logic        fault_now;

    // Length pre-decode from the first two window bytes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_len     = 3'd1;
        dec_illegal = 1'b0;
        case (fetch_data[31:24]) inside
            8'h55, 8'h5D, 8'hC3, 8'hC9: dec_len = 3'd1;
            8'h6A:                      dec_len = 3'd2;
            [8'hB8:8'hBF], 8'hE8:       dec_len = 3'd5;
            8'h89, 8'h8B: begin
                if (fetch_data[23:22] == 2'b11)      dec_len = 3'd2;
                else if (fetch_data[23:22] == 2'b01) dec_len = 3'd3;
                else                                 dec_illegal = 1'b1;
            end
            8'h83: begin
                if (fetch_data[23:22] == 2'b11)      dec_len = 3'd3;
                else if (fetch_data[23:22] == 2'b01) dec_len = 3'd4;
                else                                 dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        len_mask = 40'hFF_FFFF_FFFF;
        case (dec_len)
            3'd1:    len_mask = 40'hFF_0000_0000;
            3'd2:    len_mask = 40'hFF_FF00_0000;
            3'd3:    len_mask = 40'hFF_FFFF_0000;
            3'd4:    len_mask = 40'hFF_FFFF_FF00;
            default: len_mask = 40'hFF_FFFF_FFFF;
        endcase
    end

    // A 5-byte instruction also needs the second window at pc+4 in range.
    assign fault_now = (pc > LAST_OK) || ((dec_len == 3'd5) && ((pc + 32'd4) > LAST_OK));

    assign fetch_addr  = (state == FETCH1) ? pc + 32'd4 : pc;
    assign instr_valid = (state == VALID);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) state <= FETCH0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH0: begin
                if (redirect_valid)        state_nxt = FETCH0;
                else if (fault_now)        state_nxt = HALT;
                else if (dec_len == 3'd5)  state_nxt = FETCH1;
                else                       state_nxt = VALID;
            end
            FETCH1:  state_nxt = redirect_valid ? FETCH0 : VALID;
            VALID:   state_nxt = (redirect_valid || instr_ready) ? FETCH0 : VALID;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH0;
        endcase
    end

    // Datapath; redirect wins over accept, and HALT ignores everything but reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= RESET_PC;
            instr_pc      <= 32'd0;
            instr_bytes   <= 40'd0;
            instr_len     <= 3'd0;
            instr_illegal <= 1'b0;
            fetch_fault   <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    if (redirect_valid) begin
                        pc <= redirect_addr;
                    end else if (fault_now) begin
                        fetch_fault <= 1'b1;
                    end else begin
                        instr_bytes   <= {fetch_data, 8'h00} & len_mask;
                        instr_pc      <= pc;
                        instr_len     <= dec_len;
                        instr_illegal <= dec_illegal;
                    end
                end
                FETCH1: begin
                    if (redirect_valid) pc <= redirect_addr;
                    else                instr_bytes[7:0] <= fetch_data[31:24];
                end
                VALID: begin
                    if (redirect_valid)   pc <= redirect_addr;
                    else if (instr_ready) pc <= pc + {29'd0, instr_len};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural program memory plus a
// queue of expected bundles compared as the DUT delivers them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_pc;
    logic [39:0] instr_bytes;
    logic [2:0]  instr_len;
    logic        instr_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] pc;
        logic [39:0] bytes;
        logic [2:0]  len;
        logic        ill;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_e;
    logic [7:0] mem [0:255];
    int         n_tests = 0;
    int         n_fail  = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000000b), .MEM_BYTES(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_bytes    (instr_bytes),
        .instr_len      (instr_len),
        .instr_illegal  (instr_illegal),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Combinational program memory; bytes past the end read as zero.
    always_comb begin
        fetch_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (fetch_addr + 32'(k) < 32'd256)
                fetch_data[31-8*k -: 8] = mem[8'(fetch_addr + 32'(k))];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [39:0] b, input logic [2:0] len,
                        input logic ill);
        exp_t e;
        e.pc = pc; e.bytes = b; e.len = len; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic expect_bundle(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_sb_has_entry"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pc"},    64'(instr_pc),      64'(e.pc));
            check({tag, "_bytes"}, 64'(instr_bytes),   64'(e.bytes));
            check({tag, "_len"},   64'(instr_len),     64'(e.len));
            check({tag, "_ill"},   64'(instr_illegal), 64'(e.ill));
            last_e = e;
        end
    endtask

    task automatic redirect(input logic [31:0] addr);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h55; mem[8'h01] = 8'h5D; mem[8'h02] = 8'hC3;
        mem[8'h03] = 8'h8B; mem[8'h04] = 8'h45; mem[8'h05] = 8'h08;
        mem[8'h06] = 8'h83; mem[8'h07] = 8'hE8; mem[8'h08] = 8'h01;
        mem[8'h0b] = 8'h55; mem[8'h0c] = 8'h89; mem[8'h0d] = 8'hE5;
        mem[8'h10] = 8'hE8; mem[8'h11] = 8'hEB; mem[8'h12] = 8'hFF;
        mem[8'h13] = 8'hFF; mem[8'h14] = 8'hFF;
        mem[8'h15] = 8'h6A; mem[8'h16] = 8'h05;
        mem[8'h20] = 8'h0F; mem[8'h21] = 8'h83; mem[8'h22] = 8'h45;
        mem[8'h23] = 8'hF8; mem[8'h24] = 8'h01; mem[8'h25] = 8'hC9;
        mem[8'h30] = 8'hB8; mem[8'h31] = 8'h01; mem[8'h32] = 8'h02;
        mem[8'h33] = 8'h03; mem[8'h34] = 8'h04;
        mem[8'hF9] = 8'hB8;

        reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'd0;
        step(); step();
        check("rst_valid", 64'(instr_valid),   64'd0);
        check("rst_addr",  64'(fetch_addr),    64'h0b);
        check("rst_fault", 64'(fetch_fault),   64'd0);
        check("rst_bytes", 64'(instr_bytes),   64'd0);
        check("rst_len",   64'(instr_len),     64'd0);
        check("rst_pc",    64'(instr_pc),      64'd0);
        check("rst_ill",   64'(instr_illegal), 64'd0);

        // Sequential 55 / 89 E5 from the entry point.
        reset = 1'b1;
        instr_ready = 1'b1;
        push(32'h0b, 40'h55_0000_0000, 3'd1, 1'b0);
        push(32'h0c, 40'h89_E500_0000, 3'd2, 1'b0);
        expect_bundle("push_ebp");
        step();
        expect_bundle("mov_ebp");
        step();
        check("after_mov_addr", 64'(fetch_addr), 64'h0e);

        // 5-byte call: FETCH1 fetches pc+4, valid two cycles after FETCH0 entry.
        redirect(32'h10);
        check("call_f0_addr", 64'(fetch_addr), 64'h10);
        step();
        check("call_f1_addr",  64'(fetch_addr),  64'h14);
        check("call_f1_valid", 64'(instr_valid), 64'd0);
        step();
        check("call_valid_timing", 64'(instr_valid), 64'd1);
        push(32'h10, 40'hE8_EBFF_FFFF, 3'd5, 1'b0);
        expect_bundle("call");
        step();

        // Back-pressure: bundle held stable while ready is low.
        instr_ready = 1'b0;
        redirect(32'h03);
        push(32'h03, 40'h8B_4508_0000, 3'd3, 1'b0);
        push(32'h06, 40'h83_E801_0000, 3'd3, 1'b0);
        expect_bundle("mov_load");
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 64'(instr_valid), 64'd1);
            check("hold_bytes", 64'(instr_bytes), 64'(last_e.bytes));
            check("hold_pc",    64'(instr_pc),    64'(last_e.pc));
            check("hold_len",   64'(instr_len),   64'(last_e.len));
        end
        instr_ready = 1'b1;
        step();
        check("accept_valid", 64'(instr_valid), 64'd0);
        check("accept_addr",  64'(fetch_addr),  64'h06);
        expect_bundle("sub_imm8");
        step();

        // Redirect together with ready in VALID takes the redirect target.
        instr_ready = 1'b0;
        redirect(32'h15);
        push(32'h15, 40'h6A_0500_0000, 3'd2, 1'b0);
        expect_bundle("push_imm");
        instr_ready = 1'b1;
        redirect(32'h00);
        check("redir_addr",  64'(fetch_addr),  64'h00);
        check("redir_valid", 64'(instr_valid), 64'd0);
        push(32'h00, 40'h55_0000_0000, 3'd1, 1'b0);
        expect_bundle("redir_target");

        // Redirect during FETCH1 discards the partial 5-byte bundle.
        redirect(32'h30);
        check("mov_imm_f0_addr", 64'(fetch_addr), 64'h30);
        step();
        check("mov_imm_f1_addr", 64'(fetch_addr), 64'h34);
        redirect(32'h20);
        check("f1_redir_addr",  64'(fetch_addr),  64'h20);
        check("f1_redir_valid", 64'(instr_valid), 64'd0);
        push(32'h20, 40'h0F_0000_0000, 3'd1, 1'b1);
        push(32'h21, 40'h83_45F8_0100, 3'd4, 1'b0);
        expect_bundle("illegal");
        step();
        check("illegal_next_addr", 64'(fetch_addr), 64'h21);
        expect_bundle("sub_disp8");
        step();
        check("disp8_next_addr", 64'(fetch_addr), 64'h25);

        // Out-of-range fetch halts; redirects are ignored until reset.
        instr_ready = 1'b0;
        redirect(32'hFE);
        check("pre_fault_addr", 64'(fetch_addr),  64'hFE);
        check("pre_fault_flag", 64'(fetch_fault), 64'd0);
        step();
        check("fault_flag",  64'(fetch_fault), 64'd1);
        check("fault_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            instr_ready = 1'b1;
            redirect(32'h00);
            check("halt_addr",  64'(fetch_addr),  64'hFE);
            check("halt_valid", 64'(instr_valid), 64'd0);
            check("halt_fault", 64'(fetch_fault), 64'd1);
        end
        reset = 1'b0;
        step();
        check("rst2_fault", 64'(fetch_fault), 64'd0);
        check("rst2_addr",  64'(fetch_addr),  64'h0b);
        check("rst2_valid", 64'(instr_valid), 64'd0);

        // Second-window bound: B8 at 0xF9 needs bytes up to 0x100.
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect(32'hF9);
        check("f9_addr",  64'(fetch_addr),  64'hF9);
        check("f9_fault", 64'(fetch_fault), 64'd0);
        step();
        check("len5_fault",       64'(fetch_fault), 64'd1);
        check("len5_fault_addr",  64'(fetch_addr),  64'hF9);
        check("len5_fault_valid", 64'(instr_valid), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
